// File: rtl/mul_repadd_param.sv
// mul_repadd_param: multiplies two WIDTH-bit operands (unsigned or two's
// complement) by adding the larger magnitude into an accumulator once per
// clock while a down-counter holds the smaller magnitude.
// Handshake: start is accepted only in IDLE; busy is high outside IDLE;
// done pulses for one cycle when product is valid.
module mul_repadd_param #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_addend;
    logic             r_neg;
    logic [PW-1:0]    r_product;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_min;
    logic [WIDTH-1:0] w_max;
    logic             w_neg;
    logic [PW-1:0]    w_sum;
    logic             w_last;

    // Magnitude held as WIDTH-bit unsigned, so the most negative value maps exactly.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x);
        if ((SIGNED != 0) && x[WIDTH-1])
            return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
        else
            return x;
    endfunction

    // Applies the latched sign to the unsigned accumulated result.
    function automatic logic [PW-1:0] f_apply_sign(input logic neg, input logic [PW-1:0] x);
        if (neg)
            return (~x) + {{(PW-1){1'b0}}, 1'b1};
        else
            return x;
    endfunction

    assign w_mag_a = f_mag(a);
    assign w_mag_b = f_mag(b);
    // Ties take |a| as the addend.
    assign w_max   = (w_mag_a >= w_mag_b) ? w_mag_a : w_mag_b;
    assign w_min   = (w_mag_a >= w_mag_b) ? w_mag_b : w_mag_a;
    assign w_neg   = (SIGNED != 0) ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
    assign w_sum   = r_acc + {{WIDTH{1'b0}}, r_addend};
    assign w_last  = (r_cnt == {{(WIDTH-1){1'b0}}, 1'b1});

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = (w_min == '0) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (w_last)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE);
        product = r_product;
    end

    // Accumulator, counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_cnt    <= w_min;
                        r_addend <= w_max;
                        r_neg    <= w_neg;
                        if (w_min == '0)
                            r_product <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt - {{(WIDTH-1){1'b0}}, 1'b1};
                    if (w_last)
                        r_product <= f_apply_sign(r_neg, w_sum);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_repadd_param.sv
// Bench for mul_repadd_param: three instances (8-bit unsigned, 8-bit signed,
// 4-bit unsigned). Expected products are queued when an operation is issued
// and popped when the instance raises done.
module tb_mul_repadd_param;

    logic clk = 1'b0;
    logic rst;

    logic        u8_start, u8_busy, u8_done;
    logic [7:0]  u8_a, u8_b;
    logic [15:0] u8_product;

    logic        s8_start, s8_busy, s8_done;
    logic [7:0]  s8_a, s8_b;
    logic [15:0] s8_product;

    logic        u4_start, u4_busy, u4_done;
    logic [3:0]  u4_a, u4_b;
    logic [7:0]  u4_product;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    mul_repadd_param #(.WIDTH(8), .SIGNED(0)) dut_u8 (
        .clk(clk), .rst(rst), .start(u8_start), .a(u8_a), .b(u8_b),
        .busy(u8_busy), .done(u8_done), .product(u8_product)
    );

    mul_repadd_param #(.WIDTH(8), .SIGNED(1)) dut_s8 (
        .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b),
        .busy(s8_busy), .done(s8_done), .product(s8_product)
    );

    mul_repadd_param #(.WIDTH(4), .SIGNED(0)) dut_u4 (
        .clk(clk), .rst(rst), .start(u4_start), .a(u4_a), .b(u4_b),
        .busy(u4_busy), .done(u4_done), .product(u4_product)
    );

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return u8_done;
            1:       return s8_done;
            default: return u4_done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return u8_busy;
            1:       return s8_busy;
            default: return u4_busy;
        endcase
    endfunction

    function automatic logic [15:0] get_prod(input int sel);
        case (sel)
            0:       return u8_product;
            1:       return s8_product;
            default: return {8'h00, u4_product};
        endcase
    endfunction

    task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            0: begin u8_start = st; u8_a = a; u8_b = b; end
            1: begin s8_start = st; s8_a = a; s8_b = b; end
            default: begin u4_start = st; u4_a = a[3:0]; u4_b = b[3:0]; end
        endcase
    endtask

    // Reference product for the 8-bit instances.
    function automatic logic [15:0] model_prod(input int sel, input logic [7:0] a, input logic [7:0] b);
        int x, y, p;
        logic [31:0] pv;
        x = (sel == 1) ? int'($signed(a)) : int'(a);
        y = (sel == 1) ? int'($signed(b)) : int'(b);
        p = x * y;
        pv = p;
        return pv[15:0];
    endfunction

    function automatic int model_lat(input int sel, input logic [7:0] a, input logic [7:0] b);
        int x, y;
        x = (sel == 1) ? int'($signed(a)) : int'(a);
        y = (sel == 1) ? int'($signed(b)) : int'(b);
        if (x < 0) x = -x;
        if (y < 0) y = -y;
        return (x < y) ? x : y;
    endfunction

    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input int exp_lat, input string name);
        int k;
        logic busy_ok;
        logic [15:0] got, exp_v;
        @(posedge clk); #1;
        drive(sel, 1'b1, a, b);
        exp_q.push_back(exp_p);
        @(posedge clk); #1;
        drive(sel, 1'b0, a ^ 8'h5A, b ^ 8'hC3);
        k = 0;
        busy_ok = 1'b1;
        while (!get_done(sel) && k < 300) begin
            if (get_busy(sel) !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (get_done(sel) !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d edges, required 1", name, get_done(sel), k);
            exp_v = exp_q.pop_front();
        end else begin
            checks++;
            if (k !== exp_lat) begin
                errors++;
                $display("FAIL %s_latency: got %0d edges, required %0d", name, k, exp_lat);
            end
            checks++;
            if (busy_ok !== 1'b1 || get_busy(sel) !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy: busy dropped during operation, required 1", name);
            end
            got = get_prod(sel);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL %s_product: got 0x%04h, required 0x%04h", name, got, exp_v);
            end
            @(posedge clk); #1;
            checks++;
            if (get_done(sel) !== 1'b0 || get_busy(sel) !== 1'b0) begin
                errors++;
                $display("FAIL %s_after: done=%b busy=%b, required 0 0", name, get_done(sel), get_busy(sel));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        drive(2, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (get_busy(s) !== 1'b0 || get_done(s) !== 1'b0 || get_prod(s) !== 16'h0000) begin
                errors++;
                $display("FAIL reset_state_%0d: busy=%b done=%b product=0x%04h, required 0 0 0x0000",
                         s, get_busy(s), get_done(s), get_prod(s));
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        run_op(0, 8'd255, 8'd200, 16'hC738, 200, "u_255x200");
        run_op(0, 8'd1,   8'd255, 16'd255,  1,   "u_1x255");
        run_op(0, 8'd3,   8'd0,   16'd0,    0,   "u_3x0");
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 40));
            run_op(0, a, b, model_prod(0, a, b), model_lat(0, a, b), "u_rand");
        end
    endtask

    task automatic test_signed();
        run_op(1, 8'hF9, 8'h06, 16'hFFD6, 6,   "s_m7x6");
        run_op(1, 8'h80, 8'h80, 16'h4000, 128, "s_m128xm128");
        run_op(1, 8'h80, 8'h7F, 16'hC080, 127, "s_m128x127");
        for (int i = 0; i < 5; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            run_op(1, a, b, model_prod(1, a, b), model_lat(1, a, b), "s_rand");
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int exp_c [3] = '{3, 8, 13};
        logic [15:0] exp_v;
        @(posedge clk); #1;
        drive(0, 1'b1, 8'd10, 8'd3);
        repeat (3) exp_q.push_back(model_prod(0, 8'd10, 8'd3));
        @(posedge clk); #1;
        drive(0, 1'b1, 8'd99, 8'd77);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            if (u8_done === 1'b1) begin
                checks++;
                if (ndone >= 3 || c != exp_c[ndone]) begin
                    errors++;
                    $display("FAIL b2b_timing: done at cycle %0d, pulse %0d", c, ndone);
                end
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    checks++;
                    if (u8_product !== exp_v) begin
                        errors++;
                        $display("FAIL b2b_product: got %0d, required %0d", u8_product, exp_v);
                    end
                end
                ndone++;
            end
            if (c == 14)
                drive(0, 1'b0, 8'd10, 8'd3);
            else if (c == 2)
                drive(0, 1'b1, 8'd10, 8'd3);
            @(posedge clk); #1;
        end
        checks++;
        if (ndone !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses, required 3", ndone);
        end
        while (exp_q.size() > 0) exp_v = exp_q.pop_front();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        int spurious;
        checks++;
        if (u8_product === 16'h0000) begin
            errors++;
            $display("FAIL midrst_pre: product=0x%04h, required nonzero prior result", u8_product);
        end
        @(posedge clk); #1;
        drive(0, 1'b1, 8'd255, 8'd200);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd0, 8'd0);
        repeat (49) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (u8_busy !== 1'b0 || u8_done !== 1'b0 || u8_product !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_state: busy=%b done=%b product=0x%04h, required 0 0 0x0000",
                     u8_busy, u8_done, u8_product);
        end
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 300; i++) begin
            if (u8_done !== 1'b0 || u8_busy !== 1'b0) spurious++;
            @(posedge clk); #1;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midrst_nodone: %0d cycles with done/busy high, required 0", spurious);
        end
        run_op(0, 8'd4, 8'd5, 16'd20, 4, "u_4x5_after_rst");
    endtask

    task automatic test_width4();
        run_op(2, 8'h0F, 8'h0F, 16'd225, 15, "w4_15x15");
        run_op(2, 8'h03, 8'h0B, 16'd33,  3,  "w4_3x11");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_reset_midop();
        test_width4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
